// File: rtl/ped_request_arbiter.sv
// ped_request_arbiter: debounced pedestrian request latch with round-robin grant and timeout
module ped_request_arbiter #(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int TIMEOUT_CYC  = 500_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       b_nped_main,
    input  logic       b_nped_sec,
    input  logic       phase_end,
    input  logic       ped_done,
    output logic       grant_valid,
    output logic [1:0] grant_id,
    output logic [1:0] pending,
    output logic       grant_err
);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYC);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t              state_q, state_d;
    logic [1:0]          sync1_q, sync2_q, pressed;
    logic [1:0]          deb_q, deb_d, deb_prev_q;
    logic [1:0][DW-1:0]  dcnt_q, dcnt_d;
    logic [TW-1:0]       tcnt_q, tcnt_d;
    logic [1:0]          pending_q, pending_d, grant_id_q, grant_id_d, last_q, last_d, rise, sel;
    logic                grant_valid_q, grant_valid_d, grant_err_q, grant_err_d;

    assign pressed = ~sync2_q;

    // Per-button debounce: a level change is accepted only after it has held for DEBOUNCE_CYC+1 samples
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            dcnt_d[b] = (pressed[b] != deb_q[b] && dcnt_q[b] != DMAX) ? dcnt_q[b] + 1'b1 : '0;
            deb_d[b]  = (pressed[b] != deb_q[b] && dcnt_q[b] == DMAX) ? pressed[b] : deb_q[b];
        end
    end

    // Request latch and grant FSM; presses of the crosswalk being served are dropped
    always_comb begin
        rise          = deb_q & ~deb_prev_q;
        sel           = (pending_q == 2'b11) ? ~last_q : pending_q;
        state_d       = state_q;
        grant_valid_d = grant_valid_q;
        grant_id_d    = grant_id_q;
        last_d        = last_q;
        tcnt_d        = tcnt_q;
        grant_err_d   = grant_err_q;
        pending_d     = pending_q | (rise & ~grant_id_q);
        if (state_q == IDLE) begin
            if (phase_end && pending_q != 2'b00) begin
                state_d       = GRANT;
                grant_valid_d = 1'b1;
                grant_id_d    = sel;
                last_d        = sel;
                tcnt_d        = '0;
                pending_d     = pending_d & ~sel;
            end
        end else if (ped_done || tcnt_q == TMAX) begin
            state_d       = IDLE;
            grant_valid_d = 1'b0;
            grant_id_d    = 2'b00;
            grant_err_d   = grant_err_q | ~ped_done;
        end else begin
            tcnt_d = tcnt_q + 1'b1;
        end
    end

    // All state and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            sync1_q       <= 2'b11;
            sync2_q       <= 2'b11;
            deb_q         <= 2'b00;
            deb_prev_q    <= 2'b00;
            dcnt_q        <= '0;
            tcnt_q        <= '0;
            pending_q     <= 2'b00;
            grant_id_q    <= 2'b00;
            last_q        <= 2'b10;
            grant_valid_q <= 1'b0;
            grant_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= {b_nped_sec, b_nped_main};
            sync2_q       <= sync1_q;
            deb_q         <= deb_d;
            deb_prev_q    <= deb_q;
            dcnt_q        <= dcnt_d;
            tcnt_q        <= tcnt_d;
            pending_q     <= pending_d;
            grant_id_q    <= grant_id_d;
            last_q        <= last_d;
            grant_valid_q <= grant_valid_d;
            grant_err_q   <= grant_err_d;
        end
    end

    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign pending     = pending_q;
    assign grant_err   = grant_err_q;
endmodule

// File: tb/tb_ped_request_arbiter.sv
// tb_ped_request_arbiter: directed and random stimulus checked against a window-based reference model
module tb_ped_request_arbiter;
    localparam int D = 4;
    localparam int TO = 20;
    localparam logic [15:0] MASK = 16'((1 << (D + 1)) - 1);

    logic clk = 1'b0, rst = 1'b1, pm = 1'b0, ps = 1'b0, phase_end = 1'b0, ped_done = 1'b0;
    logic grant_valid, grant_err;
    logic [1:0] grant_id, pending;
    logic b_nped_main, b_nped_sec;
    int checks = 0, errors = 0;
    bit chk_on = 1'b0;

    assign b_nped_main = ~pm;
    assign b_nped_sec  = ~ps;

    ped_request_arbiter #(.DEBOUNCE_CYC(D), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(rst), .b_nped_main(b_nped_main), .b_nped_sec(b_nped_sec),
        .phase_end(phase_end), .ped_done(ped_done), .grant_valid(grant_valid),
        .grant_id(grant_id), .pending(pending), .grant_err(grant_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: sample history per button; a debounced level flips when the
    // D+1 synchronized samples ending two edges ago all disagree with it
    logic [15:0] hist [2];
    logic [1:0]  mdeb, mflag, mr, mpend, mold, mid, mlast, s;
    logic        mgv, merr;
    int          mtime;

    always @(posedge clk) begin
        if (rst) begin
            hist[0] = '0; hist[1] = '0;
            mdeb = 0; mflag = 0; mpend = 0; mid = 0; mlast = 2'b10;
            mgv = 0; merr = 0; mtime = 0;
        end else begin
            mr = mflag;
            mflag = 0;
            hist[0] = {hist[0][14:0], pm};
            hist[1] = {hist[1][14:0], ps};
            for (int b = 0; b < 2; b++)
                if (((hist[b] >> 2) & MASK) == (mdeb[b] ? 16'd0 : MASK)) begin
                    mdeb[b] = ~mdeb[b];
                    mflag[b] = mdeb[b];
                end
            if (!mgv) begin
                mold = mpend;
                mpend = mpend | mr;
                if (phase_end && mold != 0) begin
                    s = (mold == 2'b11) ? (mlast == 2'b01 ? 2'b10 : 2'b01) : mold;
                    mgv = 1; mid = s; mlast = s; mtime = 1;
                    mpend = mpend & ~s;
                end
            end else begin
                mpend = mpend | (mr & ~mid);
                if (ped_done) begin
                    mgv = 0; mid = 0;
                end else if (mtime == TO) begin
                    mgv = 0; mid = 0; merr = 1;
                end else mtime++;
            end
        end
    end

    always @(negedge clk) if (chk_on) begin
        check("grant_valid", grant_valid, mgv);
        check("grant_id", grant_id, mid);
        check("pending", pending, mpend);
        check("grant_err", grant_err, merr);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic e, input logic d);
        phase_end = e; ped_done = d;
        tick(1);
        phase_end = 0; ped_done = 0;
    endtask

    task automatic do_reset();
        rst = 1; tick(3); rst = 0;
    endtask

    initial begin
        int hm = 0, hs = 0;
        @(posedge clk);
        chk_on = 1;
        tick(3);
        check("rst_gv", grant_valid, 0);
        check("rst_id", grant_id, 0);
        check("rst_pend", pending, 0);
        check("rst_err", grant_err, 0);
        rst = 0;
        tick(50);
        // short glitch rejected, long press gives one request 7 cycles after first sample
        pm = 1; tick(2); pm = 0; tick(10);
        check("glitch", pending, 0);
        pm = 1; tick(7);
        check("lat6", pending, 0);
        tick(1);
        check("lat7", pending, 2'b01);
        tick(20); pm = 0; tick(10);
        pulse(1, 0);
        check("g_main", grant_id, 2'b01);
        tick(5); pulse(0, 1); tick(3);
        // both pending: main first after reset, then secondary; main press during secondary grant
        do_reset();
        pm = 1; ps = 1; tick(12); pm = 0; ps = 0; tick(8);
        check("both", pending, 2'b11);
        pulse(1, 0); tick(3); pulse(0, 1); tick(2); pulse(1, 0);
        check("g_sec", grant_id, 2'b10);
        tick(2); pm = 1; tick(10); pm = 0; tick(4); pulse(0, 1); tick(3);
        // timeout with sticky error
        pulse(1, 0); tick(25);
        check("err_sticky", grant_err, 1);
        ps = 1; tick(10); ps = 0; tick(5); pulse(1, 0); tick(3); pulse(0, 1); tick(3);
        // reset during grant; phase_end coinciding with ped_done
        pm = 1; tick(10); pm = 0; tick(5); pulse(1, 0); tick(3);
        rst = 1; tick(1); rst = 0;
        check("rst_mid", grant_valid, 0);
        pm = 1; ps = 1; tick(12); pm = 0; ps = 0; tick(5);
        pulse(1, 0); tick(2); pulse(1, 1); tick(3);
        check("pe_pd", grant_valid, 0);
        // random traffic
        for (int i = 0; i < 4000; i++) begin
            if (hm == 0) begin pm = 1'($urandom_range(0, 1)); hm = $urandom_range(1, 14); end
            if (hs == 0) begin ps = 1'($urandom_range(0, 1)); hs = $urandom_range(1, 14); end
            hm--; hs--;
            phase_end = ($urandom_range(0, 19) == 0);
            ped_done  = ($urandom_range(0, 29) == 0);
            rst       = ($urandom_range(0, 799) == 0);
            tick(1);
        end
        rst = 0; phase_end = 0; ped_done = 0;
        tick(2);
        chk_on = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
